int_ctrl: RTL and testbench

Interrupt controller that sequences the CPU's nested-interrupt handling. It edge-detects three external request lines into a pending register and picks the highest-priority pending source that outranks the level currently in service. It then handshakes entry with the CPU core and pushes the accepted number onto an internal nesting stack, popping it on `eret`. Sits between the external interrupt pins and the CPU control unit; the CPU takes `int_vec` as the handler PC.

---
 rtl/int_pkg.sv | 31 +++
 rtl/int_nest_stack.sv | 61 ++++++
 rtl/int_ctrl.sv | 112 +++++++++++
 tb/tb_int_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt controller: FSM states,
// interrupt-number width, source count, default vector layout, encoders.
package int_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam int NUM_W = 2;
  localparam int NSRC  = 3;

  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0800;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;

  // Highest set bit as interrupt number 1..NSRC, 0 when nothing is pending.
  function automatic logic [NUM_W-1:0] prio_num(input logic [NSRC-1:0] p);
    prio_num = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (p[i]) prio_num = NUM_W'(i + 1);
    end
  endfunction

  function automatic logic [NSRC-1:0] num_onehot(input logic [NUM_W-1:0] n);
    num_onehot = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (n == NUM_W'(i + 1)) num_onehot[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/int_nest_stack.sv
// Nesting stack of accepted interrupt numbers; push+pop together replaces the top,
// pop when empty and push when full (without pop) leave the stack unchanged.
module int_nest_stack
  import int_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [NUM_W-1:0] din,
  output logic [NUM_W-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             full
);

  logic [NUM_W-1:0] mem [DEPTH];
  logic [DW-1:0]    cnt;
  logic             empty;
  logic             grow;
  logic             repl;
  logic             shrink;

  assign depth  = cnt;
  assign full   = (cnt == DW'(DEPTH));
  assign empty  = (cnt == '0);
  assign grow   = push && (pop ? empty : !full);
  assign repl   = push && pop && !empty;
  assign shrink = pop && !push && !empty;

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt == DW'(i + 1)) top = mem[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // Vacated entries are zeroed so the array never holds stale levels.
      for (int i = 0; i < DEPTH; i++) begin
        if (grow && cnt == DW'(i))
          mem[i] <= din;
        else if (repl && cnt == DW'(i + 1))
          mem[i] <= din;
        else if (shrink && cnt == DW'(i + 1))
          mem[i] <= '0;
      end
      if (grow)
        cnt <= cnt + 1'b1;
      else if (shrink)
        cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Nested interrupt controller: edge-detected pending bits, priority pick, REQ/ack
// handshake with the CPU, nesting stack. Define INT_NEST_EN to allow nesting.
module int_ctrl
  import int_pkg::*;
#(
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF,
  parameter int          DEPTH      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NSRC-1:0]  irq,
  input  logic             ie,
  input  logic [NSRC-1:0]  int_clr,
  input  logic             int_ack,
  input  logic             eret,
  output logic             int_req,
  output logic [NUM_W-1:0] int_no,
  output logic [31:0]      int_vec,
  output logic [NUM_W-1:0] cur_level,
  output logic [NSRC-1:0]  pending,
  output logic             ovf
);

  localparam int DW = $clog2(DEPTH + 1);

  state_t           state;
  state_t           state_nxt;
  logic [NSRC-1:0]  irq_q;
  logic [NSRC-1:0]  rise;
  logic [NSRC-1:0]  no_oh;
  logic [NSRC-1:0]  ack_clr;
  logic [NUM_W-1:0] cand;
  logic [NUM_W-1:0] no_nxt;
  logic [NUM_W-1:0] stk_top;
  logic [DW-1:0]    stk_depth;
  logic             stk_full;
  logic             ack_acc;
  logic             eligible;
  logic             withdraw;

  assign rise     = irq & ~irq_q;
  assign cand     = prio_num(pending);
  assign ack_acc  = (state == REQ) && int_ack;
  assign no_oh    = num_onehot(int_no);
  assign ack_clr  = ack_acc ? no_oh : '0;
  // A set from a fresh edge beats a software clear, so only a real clear withdraws.
  assign withdraw = !ie || (|(int_clr & ~rise & no_oh));
  assign int_req  = (state == REQ);
  assign cur_level = (stk_depth == '0) ? '0 : stk_top;

`ifdef INT_NEST_EN
  assign eligible = ie && (cand != '0) && (cand > cur_level);
`else
  assign eligible = ie && (cand != '0) && (cur_level == '0);
`endif

  always_comb begin
    state_nxt = state;
    no_nxt    = int_no;
    case (state)
      IDLE: begin
        if (eligible) begin
          state_nxt = REQ;
          no_nxt    = cand;
        end else begin
          no_nxt = '0;
        end
      end
      REQ: begin
        if (int_ack || withdraw) begin
          state_nxt = IDLE;
          no_nxt    = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        no_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q   <= '0;
      pending <= '0;
      state   <= IDLE;
      int_no  <= '0;
      int_vec <= VEC_BASE;
      ovf     <= 1'b0;
    end else begin
      irq_q   <= irq;
      pending <= (pending & ~int_clr & ~ack_clr) | rise;
      state   <= state_nxt;
      int_no  <= no_nxt;
      int_vec <= VEC_BASE + 32'(no_nxt) * VEC_STRIDE;
      if (ack_acc && !eret && stk_full) ovf <= 1'b1;
    end
  end

  int_nest_stack #(.DEPTH(DEPTH)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (ack_acc),
    .pop   (eret),
    .din   (int_no),
    .top   (stk_top),
    .depth (stk_depth),
    .full  (stk_full)
  );

endmodule

// File: tb/tb_int_ctrl.sv
// Randomised plus directed bench for int_ctrl against a queue-based reference model;
// offers are scoreboarded and checked by an independent monitor.
module tb_int_ctrl;

  localparam int          TB_DEPTH = 2;
  localparam logic [31:0] VBASE    = 32'h0000_0800;
  localparam logic [31:0] VSTRIDE  = 32'h0000_0010;
`ifdef INT_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  irq = '0;
  logic        ie = 1'b0;
  logic [2:0]  int_clr = '0;
  logic        int_ack = 1'b0;
  logic        eret = 1'b0;
  logic        int_req;
  logic [1:0]  int_no;
  logic [31:0] int_vec;
  logic [1:0]  cur_level;
  logic [2:0]  pending;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [2:0] m_pend;
  bit [2:0] m_irq_prev;
  int       stk[$];
  bit       m_req;
  int       m_no;
  bit       m_ovf;
  int       exp_q[$];

  bit [2:0] irq_h;
  bit       ie_h;

  int_ctrl #(.VEC_BASE(VBASE), .VEC_STRIDE(VSTRIDE), .DEPTH(TB_DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq       (irq),
    .ie        (ie),
    .int_clr   (int_clr),
    .int_ack   (int_ack),
    .eret      (eret),
    .int_req   (int_req),
    .int_no    (int_no),
    .int_vec   (int_vec),
    .cur_level (cur_level),
    .pending   (pending),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int hi_bit(bit [2:0] p);
    for (int i = 2; i >= 0; i--) if (p[i]) return i + 1;
    return 0;
  endfunction

  function automatic int model_top();
    return (stk.size() > 0) ? stk[stk.size()-1] : 0;
  endfunction

  function automatic void model_reset();
    m_pend = '0; m_irq_prev = '0; stk.delete();
    m_req = 1'b0; m_no = 0; m_ovf = 1'b0; exp_q.delete();
  endfunction

  // One clock of the controller's rules, applied to the inputs of this cycle.
  function automatic void model_step(bit [2:0] irq_v, bit ie_v, bit [2:0] clr_v,
                                     bit ack_v, bit eret_v);
    bit [2:0] rise = irq_v & ~m_irq_prev;
    bit [2:0] ackm = '0;
    int       top  = model_top();
    bit       acc  = m_req && ack_v;
    int       cand;
    if (!m_req) begin
      cand = hi_bit(m_pend);
      if (ie_v && cand != 0 && (NEST ? (cand > top) : (top == 0))) begin
        m_req = 1'b1;
        m_no  = cand;
        exp_q.push_back(cand);
      end
    end else if (acc) begin
      ackm = 3'b001 << (m_no - 1);
      if (eret_v && stk.size() > 0) stk[stk.size()-1] = m_no;
      else if (eret_v || stk.size() < TB_DEPTH) stk.push_back(m_no);
      else m_ovf = 1'b1;
      m_req = 1'b0;
    end else if (!ie_v || (clr_v[m_no-1] && !rise[m_no-1])) begin
      m_req = 1'b0;
    end
    if (!acc && eret_v && stk.size() > 0) void'(stk.pop_back());
    m_pend = (m_pend & ~clr_v & ~ackm) | rise;
    m_irq_prev = irq_v;
  endfunction

  task automatic cyc(input bit [2:0] irq_v, input bit ie_v, input bit [2:0] clr_v,
                     input bit ack_v, input bit eret_v);
    @(negedge clk);
    chk("int_req", int'(int_req), int'(m_req));
    chk("pending", int'(pending), int'(m_pend));
    chk("cur_level", int'(cur_level), model_top());
    chk("ovf", int'(ovf), int'(m_ovf));
    if (!m_req) chk("int_no_idle", int'(int_no), 0);
    irq = irq_v; ie = ie_v; int_clr = clr_v; int_ack = ack_v; eret = eret_v;
    model_step(irq_v, ie_v, clr_v, ack_v, eret_v);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(irq_h, ie_h, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic ret();
    cyc(irq_h, ie_h, 3'b000, 1'b0, 1'b1);
  endtask

  task automatic try_serve(input int n, input bit with_eret);
    for (int i = 0; i < n; i++) begin
      if (m_req) begin
        cyc(irq_h, ie_h, 3'b000, 1'b1, with_eret);
        return;
      end
      idle(1);
    end
  endtask

  task automatic do_reset();
    irq = '0; ie = 1'b0; int_clr = '0; int_ack = 1'b0; eret = 1'b0;
    irq_h = '0; ie_h = 1'b1;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_int_vec", int'(int_vec), int'(VBASE));
    chk("rst_int_no", int'(int_no), 0);
    rst = 1'b0;
  endtask

  // Scoreboard monitor: each new offer must match the next queued expectation
  // and must hold steady until it ends.
  int  cur_exp = 0;
  bit  req_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      req_prev = 1'b0;
    end else begin
      if (int_req && !req_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_offer: got int_no=%0d, required no offer", int_no);
          cur_exp = int'(int_no);
        end else begin
          cur_exp = exp_q.pop_front();
        end
      end
      if (int_req) begin
        chk("offer_no", int'(int_no), cur_exp);
        chk("offer_vec", int'(int_vec), int'(VBASE + 32'(cur_exp) * VSTRIDE));
      end
      req_prev = int_req;
    end
  end

  initial begin
    do_reset();

    irq_h = 3'b001; idle(2); try_serve(6, 1'b0);
    irq_h = 3'b101; idle(3); try_serve(6, 1'b0);
    ret(); idle(1); try_serve(6, 1'b0);
    ret(); idle(1); ret(); idle(1); ret(); idle(2);

    irq_h = 3'b000; idle(2);
    irq_h = 3'b100; idle(3); try_serve(6, 1'b0);
    irq_h = 3'b110; idle(4); ret(); idle(3);
    cyc(irq_h, 1'b0, 3'b000, 1'b0, 1'b0);
    idle(1); try_serve(6, 1'b0);

    irq_h = 3'b000; idle(1);
    cyc(3'b001, 1'b1, 3'b001, 1'b0, 1'b0);
    irq_h = 3'b001; idle(2);
    ret(); ret(); ret(); idle(3); try_serve(6, 1'b0);
    irq_h = 3'b000; idle(1);
    irq_h = 3'b100; idle(2); try_serve(6, 1'b1);
    idle(2); ret(); ret(); idle(2);

    // Asynchronous reset while an offer is outstanding.
    irq_h = 3'b000; idle(1);
    irq_h = 3'b001; idle(2); try_serve(6, 1'b0);
    irq_h = 3'b011; idle(3);
    for (int i = 0; i < 6 && !m_req; i++) idle(1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_int_req", int'(int_req), 0);
    chk("arst_cur_level", int'(cur_level), 0);
    chk("arst_pending", int'(pending), 0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    irq = '0; ie = 1'b1; int_clr = '0; int_ack = 1'b0; eret = 1'b0;
    irq_h = '0; ie_h = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      bit [2:0] clr_r;
      bit       ack_r;
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 3) == 0) irq_h[b] = ~irq_h[b];
      ie_h = ($urandom_range(0, 9) != 0);
      clr_r = '0;
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 15) == 0) clr_r[b] = 1'b1;
      ack_r = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      cyc(irq_h, ie_h, clr_r, ack_r, $urandom_range(0, 7) == 0);
    end

    ie_h = 1'b0; idle(3);
    @(negedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
